fetch_queue_unit: RTL and testbench
===================================

# fetch_queue_unit

Parametrised front-end fetch block that replaces the fixed single-entry next-PC/fetch path. It generates the fetch PC, issues word requests to the instruction cache with a req/ack handshake, and buffers returned instructions with their PC+4 in a DEPTH-entry queue. Decode drains the queue through a valid/ready handshake. A redirect from the execute/memory boundary flushes the queue and squashes any in-flight cache request.

## Interface
- ADDR_WIDTH, 64: PC width.
- INST_WIDTH, 32: instruction width.
- WORD_SEL_WIDTH, 4: word-select width (words per line = 2**WORD_SEL_WIDTH).
- DEPTH, 4: queue entries (≥2).
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- entry  in  32  program entry point, zero-extended to ADDR_WIDTH.
- redirect_en  in  1  redirect fetch to redirect_target this cycle.
- redirect_target  in  ADDR_WIDTH  new fetch PC; bits [1:0] ignored, forced to 0.
- ic_req  out  1  cache request, held until ic_ack.
- ic_line_addr  out  ADDR_WIDTH-WORD_SEL_WIDTH-2  pc[ADDR_WIDTH-1:WORD_SEL_WIDTH+2].
- ic_word_select  out  WORD_SEL_WIDTH  pc[WORD_SEL_WIDTH+1:2].
- ic_ack  in  1  request complete; ic_data_out valid this cycle.
- ic_data_out  in  INST_WIDTH  fetched instruction.
- id_valid  out  1  queue head valid.
- id_inst  out  INST_WIDTH  head instruction.
- id_pc_plus4  out  ADDR_WIDTH  head PC + 4.
- id_ready  in  1  decode accepts head.

## Operation
- State machine: IDLE, REQ, DRAIN.
  - IDLE: ic_req=0. Go to REQ when `inflight_count < DEPTH`, where `inflight_count` is occupancy plus outstanding requests.
  - REQ: ic_req=1, with address from fetch_pc, stable until ack.
    - On ack: push {ic_data_out, fetch_pc+4}, then fetch_pc += 4.
    - After the ack, stay in REQ if occupancy after push/pop < DEPTH. Otherwise go to IDLE.
  - DRAIN: ic_req=1 on the squashed address. Return data is discarded on ack. Then go to REQ with fetch_pc = saved redirect target, or to IDLE if no room.
- At most one outstanding request.
- Pop when id_valid && id_ready. Push and pop in the same cycle leave occupancy unchanged.
- No push occurs when full: requests are gated by occupancy, so overflow is impossible by construction.
- Redirect handling (redirect has highest priority):
  - In every state, the queue is cleared the same cycle and id_valid=0 on the next cycle. Any pop that cycle is ignored.
  - In REQ with no ack that cycle: the target is saved and the state goes to DRAIN. The cache request is never abandoned mid-handshake.
  - In REQ with ack the same cycle: ack data is discarded and fetch_pc = target. Next state is REQ.
  - In IDLE: fetch_pc = target. Next state is REQ.
  - In DRAIN: the saved target is overwritten by the newest one. State stays DRAIN.
- PC arithmetic: modulo 2**ADDR_WIDTH. Wrap from all-ones-minus-3 to 0 is legal.
- Occupancy counter width is $clog2(DEPTH+1). Queue pointers are $clog2(DEPTH) bits, wrap-around for power-of-two DEPTH, explicit compare otherwise.

## Timing
- Reset (cycle R):
  - fetch_pc = entry & ~3; state = IDLE; queue empty.
  - ic_req=0, id_valid=0, id_inst=0, id_pc_plus4=0.
  - ic_line_addr and ic_word_select reflect entry.
- The first cycle after reset deasserts, the state goes to REQ: ic_req=1 at cycle R+2 (one registered state transition).
- Ack at cycle N:
  - Entry is visible at id_valid/id_inst at N+1 (registered queue, no bypass).
  - The next sequential request is on ic_req/address at N+1 if there is room.
- Throughput: one instruction per cycle for a 1-cycle-ack cache.
- A redirect at cycle N causes the first request on the target at N+1 (REQ with no outstanding request, or IDLE), or one cycle after the drain ack.
- Reset mid-DRAIN or mid-REQ returns to the reset state immediately. The cache is expected to be reset on the same edge.

## Test plan
- Reset with entry=0x1000 and a 1-cycle-ack cache, id_ready=1 → requests to 0x1000, 0x1004, 0x1008, ….
  - ic_line_addr=0x40, ic_word_select=0,1,2.
  - id_pc_plus4 = 0x1004, 0x1008, … with one instruction per cycle.
- id_ready=0 with DEPTH=4 → exactly 4 acks, then ic_req=0 and id_valid=1 held. Raising id_ready resumes requests the cycle after the first pop.
- Redirect to 0x2002 while REQ is waiting (ack delayed 5 cycles) → DRAIN holds the old address, that ack data is discarded, and the next request is to 0x2000. The first id_pc_plus4 is 0x2004.
- Redirect in the same cycle as an ack → data not enqueued; next ic_req at the target, with no DRAIN.
- PC wrap with entry=0xFFFFFFFC → requests at 0xFFFFFFFC, then 0x100000000.
- Reset asserted mid-DRAIN → outputs at reset values next cycle; fetch restarts at entry with the old redirect target lost.

Source files
------------

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: generates the fetch PC, runs a req/ack handshake with the
// instruction cache and buffers {instruction, PC+4} in a DEPTH-entry queue
// that decode drains with valid/ready. A redirect flushes the queue and lets
// any in-flight cache request complete before fetching from the new target.
module fetch_queue_unit #(
    parameter int ADDR_WIDTH     = 64,
    parameter int INST_WIDTH     = 32,
    parameter int WORD_SEL_WIDTH = 4,
    parameter int DEPTH          = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [31:0]                            entry,
    input  logic                                   redirect_en,
    input  logic [ADDR_WIDTH-1:0]                  redirect_target,
    output logic                                   ic_req,
    output logic [ADDR_WIDTH-WORD_SEL_WIDTH-3:0]   ic_line_addr,
    output logic [WORD_SEL_WIDTH-1:0]              ic_word_select,
    input  logic                                   ic_ack,
    input  logic [INST_WIDTH-1:0]                  ic_data_out,
    output logic                                   id_valid,
    output logic [INST_WIDTH-1:0]                  id_inst,
    output logic [ADDR_WIDTH-1:0]                  id_pc_plus4,
    input  logic                                   id_ready
);

    localparam int CNT_W    = $clog2(DEPTH + 1);
    localparam int PTR_W    = $clog2(DEPTH);
    localparam bit PTR_POW2 = (DEPTH == (1 << PTR_W));
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0]   redir_tgt_q, redir_tgt_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;

    logic [INST_WIDTH-1:0]   inst_mem [DEPTH];
    logic [ADDR_WIDTH-1:0]   pc4_mem  [DEPTH];

    logic [ADDR_WIDTH-1:0]   entry_pc;
    logic [ADDR_WIDTH-1:0]   target_pc;
    logic [ADDR_WIDTH-1:0]   pc_plus4;
    logic                    push;
    logic                    pop;
    logic                    room;

    // Pointer advance: free wrap for power-of-two depth, explicit compare otherwise.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (PTR_POW2) begin
            return p + PTR_W'(1);
        end
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign entry_pc  = ADDR_WIDTH'(entry) & WORD_MASK;
    assign target_pc = redirect_target & WORD_MASK;
    assign pc_plus4  = fetch_pc_q + ADDR_WIDTH'(4);

    // Redirect squashes both the returning word and any decode pop this cycle.
    assign push = (state_q == S_REQ) && ic_ack && !redirect_en;
    assign pop  = id_valid && id_ready && !redirect_en;
    assign room = (count_d < CNT_W'(DEPTH));

    assign ic_req         = (state_q != S_IDLE);
    assign ic_line_addr   = fetch_pc_q[ADDR_WIDTH-1:WORD_SEL_WIDTH+2];
    assign ic_word_select = fetch_pc_q[WORD_SEL_WIDTH+1:2];
    assign id_valid       = (count_q != '0);
    assign id_inst        = id_valid ? inst_mem[rd_ptr_q] : '0;
    assign id_pc_plus4    = id_valid ? pc4_mem[rd_ptr_q]  : '0;

    // Queue bookkeeping: redirect empties the queue, otherwise push/pop move pointers.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect_en) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Fetch FSM: request issue, PC advance and redirect/drain sequencing.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        redir_tgt_d = redir_tgt_q;
        case (state_q)
            S_IDLE: begin
                if (redirect_en) begin
                    fetch_pc_d = target_pc;
                    state_d    = S_REQ;
                end else if (room) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (ic_ack) begin
                    if (redirect_en) begin
                        fetch_pc_d = target_pc;
                        state_d    = S_REQ;
                    end else begin
                        fetch_pc_d = pc_plus4;
                        state_d    = room ? S_REQ : S_IDLE;
                    end
                end else if (redirect_en) begin
                    // Keep the handshake alive on the old address; fetch target after it.
                    redir_tgt_d = target_pc;
                    state_d     = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (redirect_en) begin
                    redir_tgt_d = target_pc;
                end else if (ic_ack) begin
                    fetch_pc_d = redir_tgt_q;
                    state_d    = room ? S_REQ : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state registers with synchronous reset to the entry point.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            fetch_pc_q  <= entry_pc;
            redir_tgt_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            redir_tgt_q <= redir_tgt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Queue storage: written on push, contents are don't-care while invalid.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr_q] <= ic_data_out;
            pc4_mem[wr_ptr_q]  <= pc_plus4;
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: a cache model with programmable ack latency,
// an expected-fetch-PC model and a scoreboard of queued {inst, pc+4} entries,
// plus a per-cycle vector table for the reset/streaming start-up.
module tb_fetch_queue_unit;

    localparam int AW = 64;
    localparam int IW = 32;
    localparam int WS = 4;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       entry;
    logic              redirect_en;
    logic [AW-1:0]     redirect_target;
    logic              ic_req;
    logic [AW-WS-3:0]  ic_line_addr;
    logic [WS-1:0]     ic_word_select;
    logic              ic_ack;
    logic [IW-1:0]     ic_data_out;
    logic              id_valid;
    logic [IW-1:0]     id_inst;
    logic [AW-1:0]     id_pc_plus4;
    logic              id_ready;

    always #5 clk = ~clk;

    fetch_queue_unit #(
        .ADDR_WIDTH(AW), .INST_WIDTH(IW), .WORD_SEL_WIDTH(WS), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .entry(entry),
        .redirect_en(redirect_en), .redirect_target(redirect_target),
        .ic_req(ic_req), .ic_line_addr(ic_line_addr), .ic_word_select(ic_word_select),
        .ic_ack(ic_ack), .ic_data_out(ic_data_out),
        .id_valid(id_valid), .id_inst(id_inst), .id_pc_plus4(id_pc_plus4),
        .id_ready(id_ready)
    );

    typedef struct packed {
        logic [IW-1:0] inst;
        logic [AW-1:0] pc4;
    } sb_t;

    typedef struct {
        logic          req;
        logic [AW-1:0] addr;
        logic          valid;
        logic [AW-1:0] pc4;
    } vec_t;

    sb_t           sb[$];
    vec_t          vecs[6];
    int            errors = 0;
    int            checks = 0;
    int            ack_lat;
    int            wait_cnt;
    int            n_acks;
    logic          rdy_s;
    logic [AW-1:0] exp_pc;
    logic [AW-1:0] saved_tgt;
    bit            drain_pend;

    function automatic logic [IW-1:0] mkinst(input logic [AW-1:0] a);
        return a[33:2] ^ a[63:32] ^ 32'hC0DE_5A5A;
    endfunction

    function automatic logic [AW-1:0] dut_addr();
        return {ic_line_addr, ic_word_select, 2'b00};
    endfunction

    task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reset cycle; checks reset values and re-arms the models.
    task automatic do_reset(input logic [31:0] e);
        reset = 1'b1;
        entry = e;
        redirect_en = 1'b0;
        redirect_target = '0;
        ic_ack = 1'b0;
        ic_data_out = '0;
        id_ready = 1'b0;
        @(posedge clk); #1;
        chk("rst_ic_req", ic_req, 0);
        chk("rst_id_valid", id_valid, 0);
        chk("rst_id_inst", id_inst, 0);
        chk("rst_id_pc4", id_pc_plus4, 0);
        chk("rst_addr", dut_addr(), {32'h0, e} & ~64'h3);
        reset = 1'b0;
        sb.delete();
        exp_pc = {32'h0, e} & ~64'h3;
        drain_pend = 1'b0;
        wait_cnt = 0;
        n_acks = 0;
    endtask

    // One clock: drive cache/decode/redirect, update models, check transfers.
    task automatic step(input bit redir, input logic [AW-1:0] tgt);
        sb_t e;
        logic [AW-1:0] t;
        t = tgt & ~64'h3;
        chk("id_valid", id_valid, (sb.size() != 0));
        id_ready = rdy_s;
        redirect_en = redir;
        redirect_target = tgt;
        ic_ack = ic_req && (wait_cnt >= ack_lat);
        ic_data_out = ic_ack ? mkinst(dut_addr()) : '0;
        if (id_valid && id_ready && !redir) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got pc4 %h expected no entry", id_pc_plus4);
            end else begin
                e = sb.pop_front();
                chk("pop_inst", id_inst, e.inst);
                chk("pop_pc4", id_pc_plus4, e.pc4);
                $display("pop  inst=%h pc4=%h", id_inst, id_pc_plus4);
            end
        end
        if (ic_req) begin
            if (ic_ack) begin
                chk("ack_addr", dut_addr(), exp_pc);
                $display("ack  addr=%h%s", dut_addr(), (drain_pend || redir) ? " (discarded)" : "");
                n_acks++;
                wait_cnt = 0;
                if (drain_pend) begin
                    if (redir) saved_tgt = t;
                    else begin
                        drain_pend = 1'b0;
                        exp_pc = saved_tgt;
                    end
                end else if (redir) begin
                    exp_pc = t;
                end else begin
                    e.inst = mkinst(exp_pc);
                    e.pc4 = exp_pc + 64'd4;
                    sb.push_back(e);
                    exp_pc = exp_pc + 64'd4;
                end
            end else begin
                wait_cnt++;
                if (redir) begin
                    drain_pend = 1'b1;
                    saved_tgt = t;
                end
            end
        end else if (redir) begin
            exp_pc = t;
        end
        if (redir) sb.delete();
        @(posedge clk); #1;
        redirect_en = 1'b0;
        ic_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1'b0, 64'h1000, 1'b0, 64'h0};
        vecs[1] = '{1'b1, 64'h1000, 1'b0, 64'h0};
        vecs[2] = '{1'b1, 64'h1004, 1'b1, 64'h1004};
        vecs[3] = '{1'b1, 64'h1008, 1'b1, 64'h1008};
        vecs[4] = '{1'b1, 64'h100C, 1'b1, 64'h100C};
        vecs[5] = '{1'b1, 64'h1010, 1'b1, 64'h1010};

        // Streaming from entry 0x1000 with a 1-cycle-ack cache.
        ack_lat = 0;
        rdy_s = 1'b1;
        do_reset(32'h1000);
        for (int i = 0; i < 6; i++) begin
            chk("tbl_req", ic_req, vecs[i].req);
            chk("tbl_line", ic_line_addr, vecs[i].addr[AW-1:WS+2]);
            chk("tbl_wsel", ic_word_select, vecs[i].addr[WS+1:2]);
            chk("tbl_valid", id_valid, vecs[i].valid);
            if (vecs[i].valid) chk("tbl_pc4", id_pc_plus4, vecs[i].pc4);
            step(1'b0, '0);
        end
        repeat (4) step(1'b0, '0);

        // Backpressure: queue fills after exactly DEPTH acks, resumes after first pop.
        rdy_s = 1'b0;
        do_reset(32'h1000);
        repeat (12) step(1'b0, '0);
        chk("full_acks", n_acks, DEPTH);
        chk("full_req", ic_req, 0);
        chk("full_valid", id_valid, 1);
        rdy_s = 1'b1;
        step(1'b0, '0);
        chk("resume_req", ic_req, 1);
        repeat (10) step(1'b0, '0);

        // Redirect while a slow request is pending: drain, then fetch target.
        ack_lat = 5;
        do_reset(32'h1000);
        step(1'b0, '0);
        chk("slow_req", ic_req, 1);
        step(1'b1, 64'h2002);
        for (int i = 0; i < 5; i++) begin
            chk("drain_req", ic_req, 1);
            chk("drain_addr", dut_addr(), 64'h1000);
            step(1'b0, '0);
        end
        chk("post_drain_addr", dut_addr(), 64'h2000);
        chk("post_drain_req", ic_req, 1);
        ack_lat = 0;
        step(1'b0, '0);
        chk("redir_first_valid", id_valid, 1);
        chk("redir_first_pc4", id_pc_plus4, 64'h2004);
        repeat (3) step(1'b0, '0);

        // Redirect on the same cycle as an ack: no enqueue, no drain.
        do_reset(32'h1000);
        repeat (3) step(1'b0, '0);
        step(1'b1, 64'h3000);
        chk("same_ack_req", ic_req, 1);
        chk("same_ack_addr", dut_addr(), 64'h3000);
        chk("same_ack_valid", id_valid, 0);
        step(1'b0, '0);
        chk("same_ack_pc4", id_pc_plus4, 64'h3004);

        // PC carry past 32 bits, then full 64-bit wrap to zero.
        do_reset(32'hFFFF_FFFC);
        step(1'b0, '0);
        chk("wrap32_a", dut_addr(), 64'hFFFF_FFFC);
        step(1'b0, '0);
        chk("wrap32_b", dut_addr(), 64'h1_0000_0000);
        step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("wrap64_a", dut_addr(), 64'hFFFF_FFFF_FFFF_FFFC);
        step(1'b0, '0);
        chk("wrap64_b", dut_addr(), 64'h0);
        chk("wrap64_pc4", id_pc_plus4, 64'h0);
        repeat (2) step(1'b0, '0);

        // Reset during DRAIN: old redirect target is forgotten.
        ack_lat = 5;
        do_reset(32'h1000);
        step(1'b0, '0);
        step(1'b1, 64'h5000);
        step(1'b0, '0);
        chk("mid_drain_req", ic_req, 1);
        do_reset(32'h1000);
        step(1'b0, '0);
        chk("restart_req", ic_req, 1);
        chk("restart_addr", dut_addr(), 64'h1000);
        ack_lat = 0;
        repeat (4) step(1'b0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
